// File: rtl/chain_code_pkg.sv
// Shared constants and state encoding for the chain-code serial encoder.
// Direction codes follow the decoder's numbering; CC_DONE terminates a contour.
package chain_code_pkg;

  localparam logic [3:0] CC_E    = 4'd0;
  localparam logic [3:0] CC_NE   = 4'd1;
  localparam logic [3:0] CC_N    = 4'd2;
  localparam logic [3:0] CC_NW   = 4'd3;
  localparam logic [3:0] CC_W    = 4'd4;
  localparam logic [3:0] CC_SW   = 4'd5;
  localparam logic [3:0] CC_S    = 4'd6;
  localparam logic [3:0] CC_SE   = 4'd7;
  localparam logic [3:0] CC_DONE = 4'b1000;

  localparam int DATA_BITS  = 4;
  localparam int FRAME_BITS = 6;

  typedef enum logic [2:0] {
    IDLE, WAIT_PIX, START_BIT, DATA_BIT, STOP_BIT, GAP
  } state_t;

endpackage

// File: rtl/chain_code_encoder_if.sv
// Pixel handshake, contour control and serial/status signals of the encoder.
// Handshake: a pixel transfers on a rising CLK edge where pix_valid && pix_ready.
interface chain_code_encoder_if;
  import chain_code_pkg::*;

  logic        start;
  logic [5:0]  start_pixel_x;
  logic [5:0]  start_pixel_y;
  logic        pix_valid;
  logic [5:0]  pix_x;
  logic [5:0]  pix_y;
  logic        pix_last;
  logic        pix_ready;
  logic        output_serial_bit;
  logic        busy;
  logic [3:0]  ChainCode_output;
  logic [15:0] code_count;
  logic        error;
  logic        done;
  state_t      state;

  modport master (
    output start, start_pixel_x, start_pixel_y, pix_valid, pix_x, pix_y, pix_last,
    input  pix_ready, output_serial_bit, busy, ChainCode_output, code_count,
           error, done, state
  );

  modport slave (
    input  start, start_pixel_x, start_pixel_y, pix_valid, pix_x, pix_y, pix_last,
    output pix_ready, output_serial_bit, busy, ChainCode_output, code_count,
           error, done, state
  );

endinterface

// File: rtl/chain_code_dir.sv
// Maps a signed pixel step (dx,dy) to an 8-neighbour direction code.
// valid_o is low for zero steps and for any step larger than one pixel.
module chain_code_dir
  import chain_code_pkg::*;
(
  input  logic signed [6:0] dx_i,
  input  logic signed [6:0] dy_i,
  output logic              valid_o,
  output logic [2:0]        code_o
);

  logic dx_m, dx_z, dx_p, dy_m, dy_z, dy_p;

  assign dx_m = (dx_i == -7'sd1);
  assign dx_z = (dx_i ==  7'sd0);
  assign dx_p = (dx_i ==  7'sd1);
  assign dy_m = (dy_i == -7'sd1);
  assign dy_z = (dy_i ==  7'sd0);
  assign dy_p = (dy_i ==  7'sd1);

  always_comb begin
    valid_o = 1'b1;
    code_o  = 3'd0;
    if      (dx_z && dy_m) code_o = CC_E[2:0];
    else if (dx_m && dy_m) code_o = CC_NE[2:0];
    else if (dx_p && dy_z) code_o = CC_N[2:0];
    else if (dx_p && dy_p) code_o = CC_NW[2:0];
    else if (dx_z && dy_p) code_o = CC_W[2:0];
    else if (dx_m && dy_p) code_o = CC_SW[2:0];
    else if (dx_m && dy_z) code_o = CC_S[2:0];
    else if (dx_p && dy_m) code_o = CC_SE[2:0];
    else                   valid_o = 1'b0;
  end

endmodule

// File: rtl/chain_code_encoder.sv
// Turns a stream of contour pixels into UART-style chain-code frames
// (start 0, 4 data bits LSB first, stop 1, one idle gap clock), then a terminator.
module chain_code_encoder
  import chain_code_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input logic           CLK,
  input logic           reset,
  chain_code_encoder_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t      state_q, state_d;
  logic [5:0]  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [3:0]  shreg_q, shreg_d;
  logic [3:0]  code_q, code_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [1:0]  bit_idx_q, bit_idx_d;
  logic [15:0] count_q, count_d;
  logic        pend_q, pend_d, term_q, term_d;
  logic        busy_q, busy_d, error_q, error_d, done_q, done_d;

  logic signed [6:0] dx, dy;
  logic              step_valid;
  logic [2:0]        step_code;
  logic              bit_end;

  // 7-bit difference of zero-extended coordinates: no wrap-around at the edges.
  assign dx = $signed({1'b0, bus.pix_x} - {1'b0, prev_x_q});
  assign dy = $signed({1'b0, bus.pix_y} - {1'b0, prev_y_q});

  chain_code_dir u_dir (
    .dx_i    (dx),
    .dy_i    (dy),
    .valid_o (step_valid),
    .code_o  (step_code)
  );

  assign bit_end = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    prev_x_d  = prev_x_q;
    prev_y_d  = prev_y_q;
    shreg_d   = shreg_q;
    code_d    = code_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    count_d   = count_q;
    pend_d    = pend_q;
    term_d    = term_q;
    busy_d    = busy_q;
    error_d   = error_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          prev_x_d = bus.start_pixel_x;
          prev_y_d = bus.start_pixel_y;
          count_d  = 16'd0;
          error_d  = 1'b0;
          busy_d   = 1'b1;
          pend_d   = 1'b0;
          state_d  = WAIT_PIX;
        end
      end
      WAIT_PIX: begin
        if (bus.pix_valid) begin
          clk_cnt_d = '0;
          bit_idx_d = 2'd0;
          if (bus.pix_last) pend_d = 1'b1;
          if (step_valid) begin
            shreg_d  = {1'b0, step_code};
            code_d   = {1'b0, step_code};
            prev_x_d = bus.pix_x;
            prev_y_d = bus.pix_y;
            term_d   = 1'b0;
            state_d  = START_BIT;
          end else begin
            error_d = 1'b1;
            // A rejected last pixel still has to close the contour.
            if (bus.pix_last) begin
              shreg_d = CC_DONE;
              code_d  = CC_DONE;
              term_d  = 1'b1;
              state_d = START_BIT;
            end
          end
        end
      end
      START_BIT, DATA_BIT, STOP_BIT: begin
        clk_cnt_d = clk_cnt_q + CW'(1);
        if (bit_end) begin
          clk_cnt_d = '0;
          if (state_q == START_BIT) state_d = DATA_BIT;
          else if (state_q == STOP_BIT) state_d = GAP;
          else begin
            bit_idx_d = bit_idx_q + 2'd1;
            if (bit_idx_q == 2'(DATA_BITS - 1)) state_d = STOP_BIT;
          end
        end
      end
      GAP: begin
        if (term_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
          term_d  = 1'b0;
          state_d = IDLE;
        end else begin
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if (pend_q) begin
            shreg_d = CC_DONE;
            code_d  = CC_DONE;
            term_d  = 1'b1;
            state_d = START_BIT;
          end else begin
            state_d = WAIT_PIX;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_x_q  <= 6'd0;
      prev_y_q  <= 6'd0;
      shreg_q   <= 4'd0;
      code_q    <= 4'd0;
      clk_cnt_q <= '0;
      bit_idx_q <= 2'd0;
      count_q   <= 16'd0;
      pend_q    <= 1'b0;
      term_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_x_q  <= prev_x_d;
      prev_y_q  <= prev_y_d;
      shreg_q   <= shreg_d;
      code_q    <= code_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      term_q    <= term_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  // Line is decoded from state so reset forces it high without waiting for a clock.
  always_comb begin
    bus.output_serial_bit = 1'b1;
    if (state_q == START_BIT)     bus.output_serial_bit = 1'b0;
    else if (state_q == DATA_BIT) bus.output_serial_bit = shreg_q[bit_idx_q];
  end

  assign bus.pix_ready        = (state_q == WAIT_PIX);
  assign bus.busy             = busy_q;
  assign bus.ChainCode_output = code_q;
  assign bus.code_count       = count_q;
  assign bus.error            = error_q;
  assign bus.done             = done_q;
  assign bus.state            = state_q;

endmodule

// File: doc/chain_code_encoder.md
Name: chain_code_encoder

Overview:
Transmit-side counterpart of the chain-code serial decoder. Accepts a stream of contour pixel coordinates over a valid/ready handshake and derives the 8-neighbour chain code for each step from the previous pixel. Serialises each code as a UART-style frame: start bit 0, 4 data bits LSB first, stop bit 1. After the last pixel it sends the terminator code 4'b1000. Sits between the contour tracer and the serial link to the decoder.

Parameters:
CLKS_PER_BIT, 10, clocks per serial bit; must be >= 2.

Ports:
CLK  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse that begins a contour; latches the start pixel.
start_pixel_x  input  6  start pixel x coordinate.
start_pixel_y  input  6  start pixel y coordinate.
pix_valid  input  1  next contour pixel is presented.
pix_x  input  6  next pixel x.
pix_y  input  6  next pixel y.
pix_last  input  1  qualifies pix_valid; marks the final pixel of the contour.
pix_ready  output  1  encoder accepts the pixel this cycle.
output_serial_bit  output  1  serial line; idles high.
busy  output  1  a contour is in progress (from start until the terminator frame ends).
ChainCode_output  output  4  code of the frame currently or last transmitted.
code_count  output  16  number of step frames sent in this contour; the terminator is not counted.
error  output  1  sticky; a non-adjacent or zero step was presented.
done  output  1  one-cycle pulse when the terminator frame's stop bit completes.

Behaviour:
- Reset values: output_serial_bit=1, pix_ready=0, busy=0, ChainCode_output=0, code_count=0, error=0, done=0, state=IDLE.
- Reset may be asserted mid-frame. The line returns high immediately and the partial frame is abandoned.
- States: IDLE, WAIT_PIX, START_BIT, DATA_BIT, STOP_BIT, GAP.
- IDLE: start=1 latches (start_pixel_x, start_pixel_y) as the previous pixel, clears code_count and error, sets busy=1, goes to WAIT_PIX. start in any other state is ignored.
- WAIT_PIX: pix_ready=1 only in this state. A transfer occurs when pix_valid && pix_ready.
  - dx = pix_x - prev_x and dy = pix_y - prev_y are computed as 7-bit signed values. There is no wrap-around: 63->0 is a step of -63.
  - Code map, as (dx,dy): 0:(0,-1), 1:(-1,-1), 2:(+1,0), 3:(+1,+1), 4:(0,+1), 5:(-1,+1), 6:(-1,0), 7:(+1,-1).
  - Valid step: load the code into the shift register, update prev to the new pixel, go to START_BIT.
  - Invalid step (|dx|>1, |dy|>1, or dx=dy=0): set error=1, discard the pixel (prev unchanged), send no frame, stay in WAIT_PIX.
  - If pix_last is set on the transfer, a pending-terminator flag is set, whether or not the step was valid. If the step was invalid and pix_last=1, go directly to START_BIT with code 4'b1000.
- Frame timing: START_BIT drives 0, DATA_BIT drives bits[0..3], STOP_BIT drives 1. Each bit lasts exactly CLKS_PER_BIT clocks, counted by a bit-clock counter and a 2-bit bit index.
  - ChainCode_output updates on the first cycle of START_BIT.
- GAP: holds the line at 1 for one clock. The frame therefore occupies 6*CLKS_PER_BIT+1 clocks.
- Leaving GAP:
  - After a step frame: code_count increments. If the terminator is pending, load 4'b1000 and go to START_BIT; otherwise go to WAIT_PIX.
  - After the terminator frame: pulse done=1, set busy=0, clear pending, go to IDLE.
- code_count saturates at 16'hFFFF.
- Latency from pixel accept to the falling start edge: 1 clock.

Decomposition:
- Package chain_code_pkg holds:
  - direction code localparams CC_E..CC_SE (0..7) and CC_DONE=4'b1000;
  - the state encoding;
  - frame length constants DATA_BITS=4 and FRAME_BITS=6.
- Sub-module chain_code_dir: combinational (dx,dy) -> {valid, code[2:0]}. It is shared with future tracer logic. The FSM and serialiser remain in the top module.

Test Plan:
1. CLKS_PER_BIT=10. start at (10,10), then pixel (10,9) with pix_last=1 -> frame for code 0: low 10 clocks, bits 0,0,0,0, high 10 clocks, 1 gap clock. Then the terminator frame with bits 0,0,0,1. done pulses once; code_count=1.
2. Pixels (11,11),(11,12),(10,13),(9,12) starting from (10,10) -> codes 3,4,5,1. The frame for code 3 has LSB-first data 1,1,0,0. code_count=4 before the terminator.
3. Non-adjacent pixel (13,10) after start (10,10), then (11,10) -> error=1 and no frame for (13,10). Code 2 is then sent relative to (10,10).
4. Backpressure: hold pix_valid during a frame -> pix_ready stays 0 for the full 61 clocks. The pixel is accepted in WAIT_PIX and the next start edge follows 1 clock later.
5. Assert reset mid DATA_BIT -> output_serial_bit=1, busy=0 and error=0 asynchronously. A new start then produces a clean frame.
6. Boundary: start (63,0), pixel (0,0) -> error=1 (no wrap). Pixel (62,0) then produces code 6.
